// File: rtl/x_uart_tx_arb.sv
// x_uart_tx_arb
//   Round-robin arbiter that lets p_n_req byte sources share a single UART
//   transmitter. One byte is accepted per IDLE cycle, held in a data register
//   while the transmitter is busy, then released back to IDLE on handshake.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active high
//   i_req_valid  per-requester byte valid (held until its o_req_ready)
//   i_req_data   requester k byte at [8k+7:8k]
//   i_req_last   last byte of a packet (packet-lock build only)
//   o_req_ready  one-hot single-cycle byte-accept pulse
//   o_tx_valid   byte presented to the transmitter
//   o_tx_data    byte to the transmitter
//   i_tx_ready   transmitter idle; transfer on o_tx_valid & i_tx_ready
//   o_grant      one-hot owner of the byte in flight, zero in IDLE
//   o_busy       high whenever a byte is in flight
//
// Build option
//   X_UART_ARB_PKT_LOCK_EN  when defined, a requester that sends a byte with
//                           i_req_last=0 keeps exclusive ownership until it
//                           sends a byte with i_req_last=1.
//
// States
//   ST_IDLE | no byte held; arbitrate and accept one byte this cycle
//   ST_SEND | byte held on o_tx_data, waiting for i_tx_ready
module x_uart_tx_arb #(
    parameter int p_n_req = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_n_req-1:0]     i_req_valid,
    input  logic [8*p_n_req-1:0]   i_req_data,
    input  logic [p_n_req-1:0]     i_req_last,
    output logic [p_n_req-1:0]     o_req_ready,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_ready,
    output logic [p_n_req-1:0]     o_grant,
    output logic                   o_busy
);

    localparam int PW = $clog2(p_n_req);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         data_q, data_d;
    logic [p_n_req-1:0] eligible;
    logic               found;
    logic [PW-1:0]      winner;
    logic [7:0]         win_data;

`ifdef X_UART_ARB_PKT_LOCK_EN
    // ptr_q always holds the last winner, so it doubles as the lock owner.
    logic lock_q, lock_d;
    logic win_last;

    always_comb begin
        eligible = '0;
        win_last = 1'b0;
        for (int k = 0; k < p_n_req; k++) begin
            eligible[k] = i_req_valid[k] & (~lock_q | (ptr_q == PW'(k)));
            if (winner == PW'(k)) begin
                win_last = i_req_last[k];
            end
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^i_req_last;
    assign eligible        = i_req_valid;
`endif

    // Search starts one past the previous winner and wraps, so the last
    // winner has the lowest priority next time.
    always_comb begin
        logic [PW-1:0] cand;
        found  = 1'b0;
        winner = ptr_q;
        cand   = '0;
        for (int i = 1; i <= p_n_req; i++) begin
            cand = PW'((int'(ptr_q) + i) % p_n_req);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < p_n_req; k++) begin
            if (winner == PW'(k)) begin
                win_data = i_req_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        o_req_ready = '0;
`ifdef X_UART_ARB_PKT_LOCK_EN
        lock_d      = lock_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    for (int k = 0; k < p_n_req; k++) begin
                        o_req_ready[k] = (winner == PW'(k));
                    end
                    data_d  = win_data;
                    ptr_d   = winner;
                    state_d = ST_SEND;
`ifdef X_UART_ARB_PKT_LOCK_EN
                    lock_d  = ~win_last;
`endif
                end
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(p_n_req - 1);
            data_q  <= '0;
`ifdef X_UART_ARB_PKT_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
`ifdef X_UART_ARB_PKT_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign o_busy     = (state_q == ST_SEND);
    assign o_tx_valid = o_busy;
    assign o_tx_data  = o_busy ? data_q : 8'h00;

    always_comb begin
        o_grant = '0;
        for (int k = 0; k < p_n_req; k++) begin
            o_grant[k] = o_busy && (ptr_q == PW'(k));
        end
    end

endmodule

// File: doc/x_uart_tx_arb.md
X_UART_TX_ARB -- requirements
Module: x_uart_tx_arb

Interface
REQ-001 The block SHALL have parameter p_n_req, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 i_clk  in  1  clock; all state on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req_valid  in  p_n_req  per-requester byte valid; held until matching o_req_ready.
REQ-005 i_req_data  in  8*p_n_req  requester k byte at [8k+7:8k].
REQ-006 i_req_last  in  p_n_req  last byte of packet; used only under REQ-026.
REQ-007 o_req_ready  out  p_n_req  one-hot, single-cycle byte-accept pulse.
REQ-008 o_tx_valid  out  1  byte presented to transmitter.
REQ-009 o_tx_data  out  8  byte to transmitter.
REQ-010 i_tx_ready  in  1  transmitter idle; transfer when o_tx_valid & i_tx_ready.
REQ-011 o_grant  out  p_n_req  one-hot owner of the byte in flight; zero in IDLE.
REQ-012 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 In IDLE with any eligible i_req_valid, the block SHALL pick the winner round-robin, starting search at (ptr_q+1) mod p_n_req, wrapping past p_n_req-1 to 0.
REQ-015 In that same cycle it SHALL pulse o_req_ready[winner], register the winner byte into the data register, set ptr_q to the winner, and go to SEND.
REQ-016 In SEND, o_tx_valid SHALL be 1, o_tx_data the registered byte, o_grant the winner, all stable until transfer.
REQ-017 On transfer (SEND & i_tx_ready) the block SHALL return to IDLE next cycle; o_tx_valid SHALL drop that next cycle.
REQ-018 Latency: i_req_valid rising in IDLE at cycle N -> o_req_ready at N (comb.) -> o_tx_valid at N+1.
REQ-019 Byte throughput SHALL be at most one per two cycles (SEND then IDLE); no request is dropped.
REQ-020 Valid on several requesters in the same cycle SHALL yield exactly one o_req_ready bit; others wait.
REQ-021 o_req_ready SHALL never assert in SEND or for a requester with i_req_valid low.
REQ-022 i_req_valid changes during SEND SHALL have no effect until IDLE.
REQ-023 i_tx_ready toggling while not in SEND SHALL be ignored.
REQ-024 Fairness: with all requesters continuously valid, each SHALL be granted once per p_n_req bytes.

Reset
REQ-025 On i_rst: state IDLE, ptr_q = p_n_req-1 (requester 0 first), data register 0, lock clear, outputs o_req_ready=0, o_tx_valid=0, o_tx_data=0, o_grant=0, o_busy=0; an in-flight byte SHALL be discarded.

Configuration
REQ-026 With macro X_UART_ARB_PKT_LOCK_EN defined: accepting a byte with i_req_last[winner]=0 SHALL set a lock on the winner; while locked only that requester is eligible in IDLE; accepting its byte with i_req_last=1 SHALL clear the lock.
REQ-027 With X_UART_ARB_PKT_LOCK_EN undefined: no lock state, i_req_last ignored, arbitration per byte as REQ-014.

Verification
REQ-028 Single: req1 valid 0x55, i_tx_ready=1 -> o_req_ready=0010 same cycle, o_tx_valid/o_tx_data=0x55 next cycle, o_grant=0010.
REQ-029 Contention after reset: all 4 valid -> grants order 0,1,2,3,0, one every 2 cycles.
REQ-030 Backpressure: i_tx_ready=0 for 20 cycles in SEND -> o_tx_valid, o_tx_data, o_grant stable 20 cycles, no o_req_ready pulse.
REQ-031 Reset mid-SEND: assert i_rst while o_tx_valid=1 -> all outputs 0 immediately; after release req2 and req0 valid -> req0 granted first.
REQ-032 Lock (macro on): req0 sends 3 bytes last=0,0,1 while req1 valid -> req0 x3 then req1; macro off -> req0,req1,req0,req1,req0.
